// File: rtl/keccak_pkg.sv
// Shared definitions for the Keccak sponge front end.
// Holds the lane/rate geometry, the domain-separation suffix bytes and the
// state encoding of the pad feeder FSM.
package keccak_pkg;

  localparam int DATA_SIZE  = 64;
  localparam int RATE_WORDS = 21;
  localparam int RATE_BITS  = DATA_SIZE * RATE_WORDS;

  localparam logic [7:0] DS_SHA3  = 8'h06;
  localparam logic [7:0] DS_SHAKE = 8'h1F;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    LOAD,
    PAD,
    DONE
  } state_t;

endpackage

// File: rtl/keccak_pad_lane.sv
// Combinational pad10*1 lane builder.
// Ports:
//   data_in    - message word, little-endian bytes
//   n_bytes    - number of message bytes kept from data_in (0..8)
//   ds_pending - place the domain-separation byte right after the kept bytes
//   is_lane20  - this is the last lane of the block: set the closing 0x80 bit
//   lane_out   - padded lane
module keccak_pad_lane
  import keccak_pkg::*;
#(
  parameter int         DATA_SIZE = keccak_pkg::DATA_SIZE,
  parameter logic [7:0] DSBYTE    = DS_SHAKE
) (
  input  logic [DATA_SIZE-1:0] data_in,
  input  logic [3:0]           n_bytes,
  input  logic                 ds_pending,
  input  logic                 is_lane20,
  output logic [DATA_SIZE-1:0] lane_out
);

  localparam int NB = DATA_SIZE / 8;

  // Bytes below n_bytes pass through, the suffix byte lands at index n_bytes
  // (when it fits in this lane) and everything above stays zero. The final
  // bit of the rate is ORed last so it combines with a suffix in byte 7.
  always_comb begin
    lane_out = '0;
    for (int i = 0; i < NB; i++) begin
      if (i < int'(n_bytes)) begin
        lane_out[8*i +: 8] = data_in[8*i +: 8];
      end else if (ds_pending && (i == int'(n_bytes))) begin
        lane_out[8*i +: 8] = DSBYTE;
      end
    end
    if (is_lane20) begin
      lane_out[DATA_SIZE-1] = 1'b1;
    end
  end

endmodule

// File: rtl/keccak_pad_feeder.sv
// Message feeder for the SHAKE128 rate shift register.
// Takes 64-bit message words over valid/ready, applies pad10*1 with a
// domain-separation byte and emits one lane per cycle on data_out/load_en.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   hash_init           - start (or restart) a message
//   msg_data/msg_bytes/msg_last/msg_valid/msg_ready - message stream
//   perm_ready          - permutation can absorb a new block
//   data_out, load_en   - registered lane and its strobe
//   cntr_zero           - strobe on the last lane of a block
//   last_block          - with cntr_zero on the block carrying the final pad bit
//   busy                - a hash is in progress
module keccak_pad_feeder
  import keccak_pkg::*;
#(
  parameter int         DATA_SIZE  = keccak_pkg::DATA_SIZE,
  parameter int         RATE_WORDS = keccak_pkg::RATE_WORDS,
  parameter logic [7:0] DSBYTE     = DS_SHAKE
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 hash_init,
  input  logic [DATA_SIZE-1:0] msg_data,
  input  logic [3:0]           msg_bytes,
  input  logic                 msg_last,
  input  logic                 msg_valid,
  output logic                 msg_ready,
  input  logic                 perm_ready,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 load_en,
  output logic                 cntr_zero,
  output logic                 last_block,
  output logic                 busy
);

  localparam int             CNT_W     = $clog2(RATE_WORDS);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_WORDS - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   ds_pending_q, ds_pending_d;
  logic                   msg_done_q, msg_done_d;
  logic [DATA_SIZE-1:0]   data_out_q, data_out_d;
  logic                   load_en_q, load_en_d;
  logic                   cntr_zero_q, cntr_zero_d;
  logic                   last_block_q, last_block_d;

  logic                   handshake;
  logic                   is_last_lane;
  logic                   short_last;
  logic [DATA_SIZE-1:0]   lane_data;
  logic [3:0]             lane_bytes;
  logic                   lane_ds;
  logic                   lane_l20;
  logic [DATA_SIZE-1:0]   lane;

  assign msg_ready    = (state_q == LOAD);
  assign busy         = (state_q != IDLE);
  assign handshake    = msg_valid && msg_ready;
  assign is_last_lane = (cnt_q == LAST_LANE);
  // A full 8-byte last word is plain data; its suffix spills into a pad lane.
  assign short_last   = msg_last && (msg_bytes < 4'd8);

  // Select what the lane builder sees: pad lanes are all-zero data carrying
  // the pending suffix, a short last word carries its own suffix, and any
  // other word passes through as eight data bytes.
  always_comb begin
    lane_data  = msg_data;
    lane_bytes = 4'd8;
    lane_ds    = 1'b0;
    lane_l20   = 1'b0;
    if (state_q == PAD) begin
      lane_data  = '0;
      lane_bytes = 4'd0;
      lane_ds    = ds_pending_q;
      lane_l20   = is_last_lane;
    end else if (short_last) begin
      lane_bytes = msg_bytes;
      lane_ds    = 1'b1;
      lane_l20   = is_last_lane;
    end
  end

  keccak_pad_lane #(
    .DATA_SIZE (DATA_SIZE),
    .DSBYTE    (DSBYTE)
  ) u_pad_lane (
    .data_in    (lane_data),
    .n_bytes    (lane_bytes),
    .ds_pending (lane_ds),
    .is_lane20  (lane_l20),
    .lane_out   (lane)
  );

  // Next-state logic. msg_done marks that the whole message has been taken,
  // so a block boundary leads into padding rather than more LOAD cycles;
  // ds_pending marks that the suffix byte has not been emitted yet.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ds_pending_d = ds_pending_q;
    msg_done_d   = msg_done_q;
    data_out_d   = data_out_q;
    load_en_d    = 1'b0;
    cntr_zero_d  = 1'b0;
    last_block_d = 1'b0;

    if (hash_init) begin
      state_d      = WAIT;
      cnt_d        = '0;
      ds_pending_d = 1'b0;
      msg_done_d   = 1'b0;
      data_out_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
        end
        WAIT: begin
          cnt_d = '0;
          if (perm_ready) begin
            state_d = msg_done_q ? PAD : LOAD;
          end
        end
        LOAD: begin
          if (handshake) begin
            data_out_d = lane;
            load_en_d  = 1'b1;
            if (msg_last) begin
              msg_done_d   = 1'b1;
              ds_pending_d = !short_last;
            end
            if (is_last_lane) begin
              cnt_d        = '0;
              cntr_zero_d  = 1'b1;
              last_block_d = short_last;
              state_d      = short_last ? DONE : WAIT;
            end else begin
              cnt_d   = cnt_q + 1'b1;
              state_d = msg_last ? PAD : LOAD;
            end
          end
        end
        PAD: begin
          data_out_d   = lane;
          load_en_d    = 1'b1;
          ds_pending_d = 1'b0;
          if (is_last_lane) begin
            cnt_d        = '0;
            cntr_zero_d  = 1'b1;
            last_block_d = 1'b1;
            state_d      = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_d      = IDLE;
          ds_pending_d = 1'b0;
          msg_done_d   = 1'b0;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // State and registered outputs; reset wins over every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ds_pending_q <= 1'b0;
      msg_done_q   <= 1'b0;
      data_out_q   <= '0;
      load_en_q    <= 1'b0;
      cntr_zero_q  <= 1'b0;
      last_block_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ds_pending_q <= ds_pending_d;
      msg_done_q   <= msg_done_d;
      data_out_q   <= data_out_d;
      load_en_q    <= load_en_d;
      cntr_zero_q  <= cntr_zero_d;
      last_block_q <= last_block_d;
    end
  end

  assign data_out   = data_out_q;
  assign load_en    = load_en_q;
  assign cntr_zero  = cntr_zero_q;
  assign last_block = last_block_q;

endmodule

// File: tb/tb_keccak_pad_feeder.sv
// Self-checking bench for keccak_pad_feeder (SHAKE128 suffix 8'h1F).
module tb_keccak_pad_feeder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hash_init;
  logic [63:0] msg_data;
  logic [3:0]  msg_bytes;
  logic        msg_last;
  logic        msg_valid;
  logic        msg_ready;
  logic        perm_ready;
  logic [63:0] data_out;
  logic        load_en;
  logic        cntr_zero;
  logic        last_block;
  logic        busy;

  int total = 0;
  int bad   = 0;

  localparam logic [63:0] PAD_END = 64'h8000000000000000;

  logic [63:0] cap_data [0:2047];
  logic        cap_cz   [0:2047];
  logic        cap_lb   [0:2047];
  int          cap_cnt = 0;

  typedef struct {
    logic [63:0] data;
    logic [3:0]  nbytes;
    logic [63:0] lane0;
    logic [63:0] lane1;
  } vec_t;

  vec_t vecs [6];

  keccak_pad_feeder #(
    .DATA_SIZE  (64),
    .RATE_WORDS (21),
    .DSBYTE     (8'h1F)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .hash_init  (hash_init),
    .msg_data   (msg_data),
    .msg_bytes  (msg_bytes),
    .msg_last   (msg_last),
    .msg_valid  (msg_valid),
    .msg_ready  (msg_ready),
    .perm_ready (perm_ready),
    .data_out   (data_out),
    .load_en    (load_en),
    .cntr_zero  (cntr_zero),
    .last_block (last_block),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Record every emitted lane, sampled on the falling edge.
  always @(negedge clk) begin
    if (load_en && (cap_cnt < 2048)) begin
      cap_data[cap_cnt] <= data_out;
      cap_cz[cap_cnt]   <= cntr_zero;
      cap_lb[cap_cnt]   <= last_block;
      cap_cnt           <= cap_cnt + 1;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Present one word and hold it until the handshake edge. Called and
  // returns just after a rising edge.
  task automatic applyStimulus(input logic [63:0] data, input logic [3:0] nb,
                               input logic last);
    int n;
    bit done;
    n    = 0;
    done = 0;
    msg_data  = data;
    msg_bytes = nb;
    msg_last  = last;
    msg_valid = 1'b1;
    while (!done && (n < 200)) begin
      @(negedge clk);
      if (msg_ready) done = 1;
      @(posedge clk);
      #1;
      n++;
    end
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    if (!done) begin
      total++;
      bad++;
      $display("[TB] FAIL handshake_timeout: got no msg_ready expected msg_ready within 200 cycles");
    end
  endtask

  task automatic start_hash();
    hash_init = 1'b1;
    @(posedge clk);
    #1;
    hash_init = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int limit);
    int n;
    bit idle;
    n    = 0;
    idle = 0;
    while (!idle && (n < limit)) begin
      @(negedge clk);
      if (!busy) idle = 1;
      @(posedge clk);
      #1;
      n++;
    end
    if (!idle) begin
      total++;
      bad++;
      $display("[TB] FAIL %s_idle_timeout: got busy expected idle within %0d cycles", name, limit);
    end
  endtask

  // Count lanes and strobes of a single-block padded message starting at base.
  task automatic check_single_block(input string name, input int base,
                                    input int nlanes, input logic [63:0] lane20);
    int early_cz;
    early_cz = 0;
    for (int i = 0; i < 20; i++) begin
      if (cap_cz[base+i] !== 1'b0) early_cz++;
    end
    checkOutput({name, "_lanes"}, 64'(cap_cnt - base), 64'(nlanes));
    checkOutput({name, "_early_cz"}, 64'(early_cz), 64'd0);
    checkOutput({name, "_lane20"}, cap_data[base+20], lane20);
    checkOutput({name, "_cz20"}, 64'(cap_cz[base+20]), 64'd1);
    checkOutput({name, "_lb20"}, 64'(cap_lb[base+20]), 64'd1);
  endtask

  task automatic send_words(input int count);
    for (int i = 0; i < count; i++) begin
      applyStimulus(64'h0101010101010101 * 64'(i + 1), 4'd8, 1'b0);
    end
  endtask

  initial begin
    int base;
    int viol;
    logic [63:0] mid_or;

    vecs[0] = '{data: 64'hFFFFFFFFFFFFFFFF, nbytes: 4'd0,
                lane0: 64'h000000000000001F, lane1: 64'h0};
    vecs[1] = '{data: 64'h0000000000CCBBAA, nbytes: 4'd3,
                lane0: 64'h000000001FCCBBAA, lane1: 64'h0};
    vecs[2] = '{data: 64'h8877665544332211, nbytes: 4'd7,
                lane0: 64'h1F77665544332211, lane1: 64'h0};
    vecs[3] = '{data: 64'h8877665544332211, nbytes: 4'd1,
                lane0: 64'h0000000000001F11, lane1: 64'h0};
    vecs[4] = '{data: 64'hDEADBEEFCAFEBABE, nbytes: 4'd5,
                lane0: 64'h00001FEFCAFEBABE, lane1: 64'h0};
    vecs[5] = '{data: 64'h0123456789ABCDEF, nbytes: 4'd8,
                lane0: 64'h0123456789ABCDEF, lane1: 64'h000000000000001F};

    rst_n      = 1'b0;
    hash_init  = 1'b1;
    msg_data   = '0;
    msg_bytes  = '0;
    msg_last   = 1'b0;
    msg_valid  = 1'b1;
    perm_ready = 1'b1;

    // Reset state, with hash_init and msg_valid asserted to show reset wins.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_data_out", data_out, 64'h0);
    checkOutput("rst_load_en", 64'(load_en), 64'd0);
    checkOutput("rst_cntr_zero", 64'(cntr_zero), 64'd0);
    checkOutput("rst_last_block", 64'(last_block), 64'd0);
    checkOutput("rst_msg_ready", 64'(msg_ready), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    hash_init = 1'b0;
    msg_valid = 1'b0;
    @(posedge clk);
    #1;

    // Single-word messages from the vector table.
    for (int v = 0; v < 6; v++) begin
      base = cap_cnt;
      start_hash();
      applyStimulus(vecs[v].data, vecs[v].nbytes, 1'b1);
      wait_idle($sformatf("vec%0d", v), 100);
      checkOutput($sformatf("vec%0d_lane0", v), cap_data[base], vecs[v].lane0);
      checkOutput($sformatf("vec%0d_lane1", v), cap_data[base+1], vecs[v].lane1);
      check_single_block($sformatf("vec%0d", v), base, 21, PAD_END);
    end

    // 167 bytes: suffix and final bit share byte 7 of lane 20.
    base = cap_cnt;
    start_hash();
    send_words(20);
    applyStimulus(64'h0011223344556677, 4'd7, 1'b1);
    wait_idle("m167", 100);
    checkOutput("m167_lane5", cap_data[base+5], 64'h0606060606060606);
    check_single_block("m167", base, 21, 64'h9F11223344556677);

    // 168 bytes: full data block, then a pure pad block.
    base = cap_cnt;
    start_hash();
    send_words(20);
    applyStimulus(64'hA5A5A5A5A5A5A5A5, 4'd8, 1'b1);
    wait_idle("m168", 200);
    checkOutput("m168_lanes", 64'(cap_cnt - base), 64'd42);
    checkOutput("m168_b1_lane20", cap_data[base+20], 64'hA5A5A5A5A5A5A5A5);
    checkOutput("m168_b1_cz", 64'(cap_cz[base+20]), 64'd1);
    checkOutput("m168_b1_lb", 64'(cap_lb[base+20]), 64'd0);
    checkOutput("m168_b2_lane0", cap_data[base+21], 64'h000000000000001F);
    mid_or = '0;
    for (int i = 22; i < 41; i++) mid_or = mid_or | cap_data[base+i];
    checkOutput("m168_b2_mid_zero", mid_or, 64'h0);
    checkOutput("m168_b2_lane20", cap_data[base+41], PAD_END);
    checkOutput("m168_b2_cz", 64'(cap_cz[base+41]), 64'd1);
    checkOutput("m168_b2_lb", 64'(cap_lb[base+41]), 64'd1);

    // Backpressure between blocks of an unfinished message.
    base = cap_cnt;
    start_hash();
    send_words(21);
    perm_ready = 1'b0;
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (msg_ready || load_en) viol++;
    end
    checkOutput("bp_hold", 64'(viol), 64'd0);
    @(posedge clk);
    #1;
    perm_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("bp_ready_rise", 64'(msg_ready), 64'd1);
    @(posedge clk);
    #1;
    applyStimulus(64'h0, 4'd0, 1'b1);
    wait_idle("bp", 100);
    checkOutput("bp_lanes", 64'(cap_cnt - base), 64'd42);
    checkOutput("bp_b1_cz", 64'(cap_cz[base+20]), 64'd1);
    checkOutput("bp_b1_lb", 64'(cap_lb[base+20]), 64'd0);
    checkOutput("bp_b2_lane0", cap_data[base+21], 64'h000000000000001F);
    checkOutput("bp_b2_lane20", cap_data[base+41], PAD_END);

    // hash_init during lane 10 abandons the block.
    start_hash();
    send_words(11);
    hash_init = 1'b1;
    @(posedge clk);
    #1;
    hash_init = 1'b0;
    @(negedge clk);
    checkOutput("abort_load_en", 64'(load_en), 64'd0);
    checkOutput("abort_data_out", data_out, 64'h0);
    checkOutput("abort_msg_ready", 64'(msg_ready), 64'd0);
    @(posedge clk);
    #1;
    base = cap_cnt;
    applyStimulus(64'h0, 4'd0, 1'b1);
    wait_idle("abort", 100);
    checkOutput("abort_lane0", cap_data[base], 64'h000000000000001F);
    check_single_block("abort", base, 21, PAD_END);

    // Reset during lane 10.
    start_hash();
    send_words(11);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("mrst_load_en", 64'(load_en), 64'd0);
    checkOutput("mrst_data_out", data_out, 64'h0);
    checkOutput("mrst_busy", 64'(busy), 64'd0);
    checkOutput("mrst_msg_ready", 64'(msg_ready), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    base = cap_cnt;
    start_hash();
    applyStimulus(64'h0, 4'd0, 1'b1);
    wait_idle("mrst", 100);
    checkOutput("mrst_lane0", cap_data[base], 64'h000000000000001F);
    check_single_block("mrst", base, 21, PAD_END);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/keccak_pad_feeder.md
Name: keccak_pad_feeder

Overview:
- Upstream feeder for the 1344-bit rate shift register of the Keccak sponge (SHAKE128, 21 lanes of 64 bits).
- Accepts the message as a stream of 64-bit words over a valid/ready handshake and applies Keccak pad10*1 with a domain-separation byte.
- Emits one lane per cycle to the shift register on `data_out`/`load_en`, and pulses `cntr_zero` on the 21st lane of every block.
- Holds off the next block until the permutation reports it is ready.

Parameters:
- DATA_SIZE, 64, lane width in bits.
- RATE_WORDS, 21, lanes per rate block (1344/64).
- DSBYTE, 8'h1F, domain-separation suffix byte (8'h06 for SHA3).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- hash_init  in  1  synchronous start pulse: abort any hash in progress and begin a new message.
- msg_data  in  DATA_SIZE  message word, little-endian (byte i at bits [8i+7:8i]).
- msg_bytes  in  4  valid bytes in msg_data (0..8); only meaningful with msg_last.
- msg_last  in  1  this word is the final message word.
- msg_valid  in  1  msg_data/msg_bytes/msg_last valid.
- msg_ready  out  1  feeder accepts a word this cycle.
- perm_ready  in  1  downstream can absorb a new block (permutation idle).
- data_out  out  DATA_SIZE  lane to the rate register (registered).
- load_en  out  1  data_out valid; shift it in (registered, 1-cycle pulse per lane).
- cntr_zero  out  1  high together with load_en on lane 20 of a block.
- last_block  out  1  high with cntr_zero on the final (padded) block.
- busy  out  1  hash in progress (any state other than IDLE).

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, word counter=0.
  - data_out=0, load_en=0, cntr_zero=0, last_block=0, msg_ready=0, busy=0.
  - Reset overrides hash_init and all other inputs.
- States:
  - IDLE: on hash_init go to WAIT.
  - WAIT: counter=0; when perm_ready=1 go to LOAD.
  - LOAD:
    - msg_ready=1 (combinational on state).
    - Each msg_valid&&msg_ready handshake emits one lane the next cycle and increments the counter.
    - Gaps are allowed; load_en=0 in cycles without a handshake.
  - PAD: msg_ready=0; emits one pad lane per cycle with no gaps until lane 20.
  - DONE: emitted the final block; returns to IDLE next cycle.
- Latency: word accepted at edge t appears on data_out with load_en=1 after edge t (1 cycle).
- Non-last words: msg_bytes ignored and treated as 8.
- Last word with n<8 bytes:
  - Lane = data bytes 0..n-1, DSBYTE at byte n, zeros above.
  - If the lane is lane 20, byte 7 is additionally ORed with 8'h80.
  - Next state: DONE if this was lane 20, else PAD.
- Last word with n=8:
  - Lane is pure data.
  - The DSBYTE goes in the first pad lane at byte 0.
  - If that was lane 20, go to WAIT and start a full pad block.
- PAD lanes:
  - Zero, except the lane holding the pending DSBYTE.
  - Lane 20 has bit 63 set; if DSBYTE also lands at byte 7, that byte is DSBYTE|8'h80.
- Block end:
  - After lane 20 (cntr_zero=1), the counter wraps to 0.
  - If the message is not finished, go to WAIT.
  - At least one cycle passes before the next lane; the next lane needs perm_ready=1.
- last_block=1 only alongside cntr_zero on the block containing the 8'h80 bit.
- hash_init in any non-IDLE state:
  - Synchronously go to WAIT with counter=0 and no lane emitted that cycle.
  - Any partially emitted block is abandoned.
- msg_valid while not in LOAD: ignored (msg_ready=0, data held by the source).

Decomposition:
- Shared package keccak_pkg:
  - DATA_SIZE, RATE_WORDS, RATE_BITS=1344.
  - Domain constants DS_SHA3=8'h06, DS_SHAKE=8'h1F.
  - State enum {IDLE, WAIT, LOAD, PAD, DONE}.
- Sub-module keccak_pad_lane (combinational): inputs data, byte count, ds_pending, is_lane20; output the padded lane.
- Counter and FSM stay in the top module.

Test Plan:
- Empty message: hash_init, perm_ready=1, one word with msg_last=1, msg_bytes=0 → lane0=64'h000000000000001F, lanes1..19=0, lane20=64'h8000000000000000 with cntr_zero=1, last_block=1; 21 load_en pulses total.
- 3-byte message msg_data=64'h0000000000CCBBAA, msg_bytes=3, last → lane0=64'h000000001FCCBBAA, lane20=64'h8000000000000000.
- 167 bytes (20 full words + 7-byte last word 64'h00112233445566 77) → lane20 byte7=8'h9F, i.e. 64'h9F11223344556677, cntr_zero=1, last_block=1, single block.
- 168 bytes (21 full words) → block1 has 21 data lanes, cntr_zero=1, last_block=0; after perm_ready, block2 lane0=64'h1F, lane20=64'h8000000000000000, last_block=1.
- Backpressure: perm_ready=0 after block1 → msg_ready=0 and no load_en for 10 cycles; perm_ready=1 → msg_ready rises next cycle.
- rst_n=0 during lane 10, or hash_init during lane 10 → all outputs zero next cycle and counter restarts; a following empty message reproduces the first scenario exactly.
